reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump_pkg.sv | 18 +
 rtl/reg_dump.sv | 118 +++++++++++
 tb/tb_reg_dump.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register dump block.
// Macro REG_DUMP_CHECKSUM_EN adds the trailing checksum state.
package reg_dump_pkg;

    localparam int BYTE_W       = 8;
    localparam int DEF_NUM_REGS = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
`ifdef REG_DUMP_CHECKSUM_EN
        CKSUM,
`endif
        DONE
    } state_t;

endpackage

// File: rtl/reg_dump.sv
// Streams NUM_REGS bytes read from an external register bank, one snapshot per FETCH.
// Macro REG_DUMP_CHECKSUM_EN appends an XOR checksum byte after the last register.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [BYTE_W-1:0] r_data,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    // Stream handshake: a byte transfers on any rising edge where out_valid and
    // out_ready are both 1; once out_valid rises, it and out_data hold until then.

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [BYTE_W-1:0]   data_q, data_d;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [BYTE_W-1:0]   cksum_q, cksum_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            index_q <= '0;
            data_q  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            cksum_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            data_q  <= data_d;
`ifdef REG_DUMP_CHECKSUM_EN
            cksum_q <= cksum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        data_d    = data_q;
`ifdef REG_DUMP_CHECKSUM_EN
        cksum_d   = cksum_q;
`endif
        out_valid = 1'b0;
        out_data  = data_q;
        busy      = 1'b1;
        done      = 1'b0;
        r_addr    = '0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = FETCH;
                    index_d = '0;
`ifdef REG_DUMP_CHECKSUM_EN
                    cksum_d = '0;
`endif
                end
            end
            FETCH: begin
                // Snapshot here so later bank writes cannot disturb the pending byte.
                r_addr  = index_q;
                data_d  = r_data;
                state_d = SEND;
            end
            SEND: begin
                r_addr    = index_q;
                out_valid = 1'b1;
                if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    cksum_d = cksum_q ^ data_q;
`endif
                    if (index_q != LAST_IDX) begin
                        index_d = index_q + ADDR_W'(1);
                        state_d = FETCH;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_d = CKSUM;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CKSUM: begin
                out_valid = 1'b1;
                out_data  = cksum_q;
                if (out_ready) state_d = DONE;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: a 4-entry instance and a 1-entry instance.
module tb_reg_dump;
    import reg_dump_pkg::*;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, out_ready;
    logic [1:0] r_addr;
    logic [7:0] r_data, out_data;
    logic       out_valid, busy, done;
    state_t     dbg_state;
    logic [7:0] bank [4];
    assign r_data = bank[r_addr];

    logic       start1, out_ready1;
    logic [0:0] r_addr1;
    logic [7:0] r_data1, out_data1;
    logic       out_valid1, busy1, done1;
    state_t     dbg_state1;
    logic [7:0] bank1 [2];
    assign r_data1 = bank1[r_addr1];

    reg_dump #(.NUM_REGS(4), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .r_addr(r_addr), .r_data(r_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    reg_dump #(.NUM_REGS(1), .ADDR_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .r_addr(r_addr1), .r_data(r_data1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .busy(busy1), .done(done1), .dbg_state(dbg_state1)
    );

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    int done_cnt = 0;
    int done1_cnt = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp1_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL stream_extra: got %0h, expected no byte", out_data);
            end else begin
                check("stream_byte", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
        end
        if (done) done_cnt++;
    end

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            if (exp1_q.size() == 0) begin
                n_total++;
                $display("FAIL stream1_extra: got %0h, expected no byte", out_data1);
            end else begin
                check("stream1_byte", {24'h0, out_data1}, {24'h0, exp1_q.pop_front()});
            end
        end
        if (done1) done1_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_dump(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        if (CK) exp_q.push_back(b0 ^ b1 ^ b2 ^ b3);
    endtask

    task automatic load_bank(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        bank[0] = b0; bank[1] = b1; bank[2] = b2; bank[3] = b3;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done_seen"}, {31'h0, done}, 32'h1);
        @(negedge clk);
        check({name, "_busy_after_done"}, {31'h0, busy}, 32'h0);
        check({name, "_done_one_cycle"}, {31'h0, done}, 32'h0);
        check({name, "_queue_empty"}, exp_q.size(), 32'h0);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_valid_seen"}, {31'h0, out_valid}, 32'h1);
    endtask

    // Hold out_ready low for 'stalls' sampled cycles, then accept exactly one byte.
    task automatic accept_byte(input logic [7:0] exp, input int stalls);
        wait_valid("accept");
        for (int s = 0; s < stalls; s++) begin
            check("stall_valid", {31'h0, out_valid}, 32'h1);
            check("stall_data", {24'h0, out_data}, {24'h0, exp});
            if (s < stalls - 1) @(negedge clk);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0; out_ready = 1'b0; out_ready1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_r_addr", {30'h0, r_addr}, 32'h0);
        check("rst_out_data", {24'h0, out_data}, 32'h0);
        check("rst_state", {29'h0, dbg_state}, {29'h0, IDLE});
        check("rst1_busy", {31'h0, busy1}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        load_bank(8'h11, 8'h22, 8'h33, 8'h44);
        bank1[0] = 8'h7E; bank1[1] = 8'h00;
        do_reset();

        // Basic dump with a free-running sink, plus start-to-valid latency.
        tick();
        out_ready = 1'b1;
        push_dump(8'h11, 8'h22, 8'h33, 8'h44);
        d0 = done_cnt;
        pulse_start();
        @(negedge clk);
        check("lat_fetch_valid", {31'h0, out_valid}, 32'h0);
        check("lat_fetch_busy", {31'h0, busy}, 32'h1);
        check("lat_fetch_r_addr", {30'h0, r_addr}, 32'h0);
        @(negedge clk);
        check("lat_send_valid", {31'h0, out_valid}, 32'h1);
        wait_done("basic");
        repeat (3) tick();
        check("basic_done_count", done_cnt - d0, 32'h1);
        check("idle_r_addr", {30'h0, r_addr}, 32'h0);

        // Back-pressure: five low-ready cycles on each byte.
        out_ready = 1'b0;
        load_bank(8'hA5, 8'h0F, 8'hF0, 8'h01);
        push_dump(8'hA5, 8'h0F, 8'hF0, 8'h01);
        pulse_start();
        accept_byte(8'hA5, 5);
        accept_byte(8'h0F, 5);
        accept_byte(8'hF0, 5);
        accept_byte(8'h01, 5);
        if (CK) accept_byte(8'h5B, 5);
        wait_done("stall");

        // Bank writes during SEND of index 1.
        load_bank(8'h11, 8'h22, 8'h33, 8'h44);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h99);
        exp_q.push_back(8'h44);
        if (CK) exp_q.push_back(8'hEE);
        pulse_start();
        accept_byte(8'h11, 1);
        wait_valid("snap");
        check("snap_r_addr", {30'h0, r_addr}, 32'h1);
        bank[1] = 8'h99;
        bank[2] = 8'h99;
        accept_byte(8'h22, 2);
        accept_byte(8'h99, 1);
        accept_byte(8'h44, 1);
        if (CK) accept_byte(8'hEE, 1);
        wait_done("snap");

        // start held high for a whole dump: exactly one dump.
        load_bank(8'h01, 8'h02, 8'h04, 8'h08);
        out_ready = 1'b1;
        push_dump(8'h01, 8'h02, 8'h04, 8'h08);
        d0 = done_cnt;
        start = 1'b1;
        wait_done("hold");
        start = 1'b0;
        repeat (5) tick();
        check("hold_done_count", done_cnt - d0, 32'h1);
        check("hold_no_restart", {31'h0, busy}, 32'h0);
        push_dump(8'h01, 8'h02, 8'h04, 8'h08);
        pulse_start();
        wait_done("restart");

        // Reset in the middle of SEND for index 2.
        out_ready = 1'b0;
        load_bank(8'h11, 8'h22, 8'h33, 8'h44);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        pulse_start();
        accept_byte(8'h11, 1);
        accept_byte(8'h22, 1);
        wait_valid("midrst");
        check("midrst_r_addr", {30'h0, r_addr}, 32'h2);
        check("midrst_data", {24'h0, out_data}, 32'h33);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_r_addr_zero", {30'h0, r_addr}, 32'h0);
        check("midrst_queue", exp_q.size(), 32'h0);
        out_ready = 1'b1;
        push_dump(8'h11, 8'h22, 8'h33, 8'h44);
        pulse_start();
        wait_done("after_rst");

        // Single-register instance.
        out_ready1 = 1'b1;
        exp1_q.push_back(8'h7E);
        if (CK) exp1_q.push_back(8'h7E);
        d0 = done1_cnt;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (8) tick();
        check("one_done_count", done1_cnt - d0, 32'h1);
        check("one_queue_empty", exp1_q.size(), 32'h0);
        check("one_busy", {31'h0, busy1}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
